// File: rtl/pulse_synchronizer.sv
// pulse_synchronizer
//
// Receive-side synchronizer for a slow-to-fast clock domain crossing. An
// asynchronous level/event on `pulse` is passed through a SYNC_STAGES-deep
// flop chain clocked by clkB. The synchronized level is edge-detected, and one
// clkB-wide pulse is produced on `q` for every qualifying transition.
//
// Parameters:
//   SYNC_STAGES  number of synchronizer flops (2..4)
//   EDGE_SEL     qualifying edge: 0 = rising, 1 = falling, 2 = both
//
// Ports:
//   clkB        in   destination clock, rising-edge active
//   rst         in   asynchronous active-high reset, clears all state at once
//   pulse       in   asynchronous event/level from the source domain
//   q           out  registered single-cycle pulse per qualifying edge
//   pulse_sync  out  synchronized copy of pulse (last synchronizer stage)
//   armed       out  high once edge detection is enabled after reset release

module pulse_synchronizer #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_SEL    = 0
) (
  input  logic clkB,
  input  logic rst,
  input  logic pulse,
  output logic q,
  output logic pulse_sync,
  output logic armed
);

  // The arm delay covers the time a level present at release needs to reach
  // prev, so that level is never mistaken for a fresh edge.
  localparam int unsigned ArmCycles = SYNC_STAGES + 1;
  localparam int unsigned CntW      = $clog2(ArmCycles + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   armed_q, armed_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   q_q, q_d;

  logic rise, fall, sel;

  // Synchronizer chain: bit 0 is the only flop that sees the async input.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pulse};
  end

  // Edge detect on the synchronized level against its one-cycle-old copy.
  always_comb begin
    rise = sync_q[SYNC_STAGES-1] & ~prev_q;
    fall = ~sync_q[SYNC_STAGES-1] & prev_q;
    case (EDGE_SEL)
      32'd1:   sel = fall;
      32'd2:   sel = rise | fall;
      default: sel = rise;
    endcase
  end

  // prev keeps tracking while disarmed; only q is gated by armed.
  always_comb begin
    prev_d  = sync_q[SYNC_STAGES-1];
    cnt_d   = cnt_q;
    armed_d = armed_q;
    if (!armed_q) begin
      cnt_d = cnt_q + CntW'(1);
      if (cnt_q == CntW'(ArmCycles - 1)) begin
        armed_d = 1'b1;
      end
    end
    q_d = armed_q & sel;
  end

  always_ff @(posedge clkB or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
      cnt_q   <= '0;
      q_q     <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
    end
  end

  assign q          = q_q;
  assign pulse_sync = sync_q[SYNC_STAGES-1];
  assign armed      = armed_q;

endmodule

// File: tb/tb_pulse_synchronizer.sv
// Self-checking bench for pulse_synchronizer. Five instances with different
// SYNC_STAGES/EDGE_SEL share one stimulus. The reference model keeps the
// history of pulse values sampled on each clkB edge since reset release and
// derives every expected output from that history with plain arithmetic.

module tb_pulse_synchronizer;

  logic       clk_b;
  logic       rst;
  logic       pulse;
  logic [4:0] q_w;
  logic [4:0] ps_w;
  logic [4:0] armed_w;

  int ss[5] = '{2, 2, 2, 3, 4};
  int ee[5] = '{0, 1, 2, 2, 0};

  pulse_synchronizer #(.SYNC_STAGES(2), .EDGE_SEL(0)) u_d0 (
    .clkB(clk_b), .rst(rst), .pulse(pulse), .q(q_w[0]), .pulse_sync(ps_w[0]), .armed(armed_w[0])
  );
  pulse_synchronizer #(.SYNC_STAGES(2), .EDGE_SEL(1)) u_d1 (
    .clkB(clk_b), .rst(rst), .pulse(pulse), .q(q_w[1]), .pulse_sync(ps_w[1]), .armed(armed_w[1])
  );
  pulse_synchronizer #(.SYNC_STAGES(2), .EDGE_SEL(2)) u_d2 (
    .clkB(clk_b), .rst(rst), .pulse(pulse), .q(q_w[2]), .pulse_sync(ps_w[2]), .armed(armed_w[2])
  );
  pulse_synchronizer #(.SYNC_STAGES(3), .EDGE_SEL(2)) u_d3 (
    .clkB(clk_b), .rst(rst), .pulse(pulse), .q(q_w[3]), .pulse_sync(ps_w[3]), .armed(armed_w[3])
  );
  pulse_synchronizer #(.SYNC_STAGES(4), .EDGE_SEL(0)) u_d4 (
    .clkB(clk_b), .rst(rst), .pulse(pulse), .q(q_w[4]), .pulse_sync(ps_w[4]), .armed(armed_w[4])
  );

  initial clk_b = 1'b0;
  always #5 clk_b = ~clk_b;

  int checks = 0;
  int errors = 0;

  // Model state: n = clkB edges since reset release, hist[k] = pulse at edge k.
  int n = 0;
  bit hist[int];

  // Phase tracking for the three-pulse count/spacing checks on u_d0.
  bit track = 1'b0;
  int q_cnt0 = 0;
  int last_q_n0 = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit val(input int k);
    if (k < 1) return 1'b0;
    if (!hist.exists(k)) return 1'b0;
    return hist[k];
  endfunction

  function automatic bit qualifies(input int e, input bit now_v, input bit old_v);
    bit r = now_v & ~old_v;
    bit f = ~now_v & old_v;
    if (e == 1) return f;
    if (e == 2) return r | f;
    return r;
  endfunction

  task automatic check_all();
    for (int i = 0; i < 5; i++) begin
      int s = ss[i];
      bit exp_ps = val(n - s + 1);
      bit exp_arm = (n >= s + 1);
      bit exp_q = (n >= s + 2) && qualifies(ee[i], val(n - s), val(n - s - 1));
      check($sformatf("d%0d_pulse_sync", i), ps_w[i], exp_ps);
      check($sformatf("d%0d_armed", i), armed_w[i], exp_arm);
      check($sformatf("d%0d_q", i), q_w[i], exp_q);
    end
  endtask

  task automatic tick();
    @(posedge clk_b);
    if (rst) begin
      n = 0;
      hist.delete();
    end else begin
      n++;
      hist[n] = pulse;
    end
    #1;
    check_all();
    if (track && q_w[0]) begin
      if (q_cnt0 > 0) check("d0_q_spacing", n - last_q_n0, 8);
      q_cnt0++;
      last_q_n0 = n;
    end
  endtask

  task automatic drive_level(input bit v, input int cycles);
    pulse = v;
    repeat (cycles) tick();
  endtask

  // Asserts reset between clock edges; outputs must clear without a clock.
  task automatic async_reset();
    #3;
    rst = 1'b1;
    #1;
    n = 0;
    hist.delete();
    check_all();
  endtask

  initial begin
    rst   = 1'b1;
    pulse = 1'b0;

    // Reset held with pulse toggling: all outputs stay at zero.
    for (int i = 0; i < 6; i++) drive_level(~pulse, 1);
    pulse = 1'b0;
    rst = 1'b0;
    drive_level(1'b0, 8);

    // Single 4-cycle pulse, then three back-to-back 4-high/4-low pulses.
    drive_level(1'b1, 4);
    drive_level(1'b0, 8);
    track = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_level(1'b1, 4);
      drive_level(1'b0, 4);
    end
    drive_level(1'b0, 6);
    track = 1'b0;
    check("d0_three_pulse_count", q_cnt0, 3);

    // Level high at reset release: no spurious q, then one q on a new rise.
    async_reset();
    pulse = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    drive_level(1'b1, 10);
    drive_level(1'b0, 6);
    drive_level(1'b1, 6);
    drive_level(1'b0, 6);

    // Reset one cycle after pulse rises: in-flight edge is discarded.
    drive_level(1'b1, 1);
    async_reset();
    tick();
    tick();
    rst = 1'b0;
    drive_level(1'b1, 4);
    drive_level(1'b0, 6);
    drive_level(1'b1, 4);
    drive_level(1'b0, 8);

    // Randomized level sequence, including widths below the contract minimum.
    for (int i = 0; i < 200; i++) begin
      drive_level(~pulse, $urandom_range(1, 10));
      if ($urandom_range(0, 39) == 0) begin
        async_reset();
        repeat ($urandom_range(1, 3)) tick();
        rst = 1'b0;
      end
    end
    drive_level(1'b0, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
